// File: rtl/mine_pkg.sv
// mine_pkg: shared types and helpers for the minesweeper game controller.
//   game_state_t : FSM encoding, also driven out on mine_ctrl.game_state
//   cmd_op_t     : player command opcodes carried on cmd_op
//   DIR_*        : MOVE direction codes carried on cmd_dir
//   cells_adjacent() : 8-neighbourhood test on the row-major cell numbering
package mine_pkg;

    typedef enum logic [2:0] {
        PLACE = 3'd0,
        PLAY  = 3'd1,
        FLOOD = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        MOVE   = 2'd0,
        REVEAL = 2'd1,
        NEW    = 2'd2,
        RSVD   = 2'd3
    } cmd_op_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    // Cells are numbered row*gs + col with row 0 at the bottom and col 0 at
    // the right; two distinct cells are neighbours when both row and column
    // differ by at most one. Edges and corners simply have fewer neighbours.
    function automatic logic cells_adjacent(input int a, input int b, input int gs);
        int dr;
        int dc;
        dr = (a / gs) - (b / gs);
        dc = (a % gs) - (b % gs);
        if (a == b) begin
            return 1'b0;
        end else begin
            return (dr >= -32'sd1) && (dr <= 32'sd1) && (dc >= -32'sd1) && (dc <= 32'sd1);
        end
    endfunction

endpackage

// File: rtl/mine_ctrl_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) used for bomb placement.
//   clk   : clock
//   reset : synchronous active-high, loads SEED
//   q     : current LFSR value, advances every cycle outside reset
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Shift register; feedback XORs taps 16,14,13,11 (bits 15,13,12,10)
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/mine_ctrl.sv
// mine_ctrl: sequential minesweeper controller sitting upstream of `board`.
// Owns the bomb / reveal / cursor grids, places bombs from an LFSR, commits
// cursor moves, flood-reveals empty regions and detects win / lose.
//   clk, reset          : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (accepted when both high)
//   cmd_op/cmd_dir/cmd_grid : command opcode, MOVE direction, NEW bomb grid
//   bombGrid/revealGrid/cursorGrid : registered grids driven into `board`
//   move, dir           : combinational move strobe and direction to `board`
//   states              : per-cell state from `board` (0-8 count, 9 bomb)
//   nextCursorGrid      : cursor after the requested move, 0 if off-grid
//   game_state          : current FSM state
module mine_ctrl
    import mine_pkg::*;
#(
    parameter int          GRID_SIZE  = 3,
    parameter int          STATE_SIZE = 4,
    parameter int          NUM_BOMBS  = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [1:0]                              cmd_op,
    input  logic [1:0]                              cmd_dir,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]          cmd_grid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          bombGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          revealGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          cursorGrid,
    output logic                                    move,
    output logic [1:0]                              dir,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]          nextCursorGrid,
    output logic [2:0]                              game_state
);

    localparam int N    = GRID_SIZE * GRID_SIZE;
    localparam int IDXW = $clog2(N);
    localparam int CNTW = $clog2(N + 1);
    localparam logic [N-1:0] GRID_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CELL0     = {{(N-1){1'b0}}, 1'b1};

    game_state_t     state_r,  state_s;
    logic [N-1:0]    bomb_r,   bomb_s;
    logic [N-1:0]    reveal_r, reveal_s;
    logic [N-1:0]    cursor_r, cursor_s;
    logic [CNTW-1:0] count_r,  count_s;
    logic            ready_r,  ready_s;
    logic            new_game_s;

    logic [15:0]     lfsr_q_s;
    logic            lfsr_unused_s;
    logic [IDXW-1:0] place_idx_s;
    logic [N-1:0]    place_bit_s;
    logic            place_ok_s;

    cmd_op_t         op_s;
    logic            accept_s;
    logic [N-1:0]    zero_s;
    logic [N-1:0]    flood_new_s;
    logic [N-1:0]    nbr_mask_s [N];

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q_s)
    );

    assign place_idx_s   = lfsr_q_s[IDXW-1:0];
    assign lfsr_unused_s = ^lfsr_q_s[15:IDXW];
    assign place_bit_s   = CELL0 << place_idx_s;
    // Only indices that name a real, still-empty cell can take a bomb
    assign place_ok_s    = (32'(place_idx_s) < N) && ((bomb_r & place_bit_s) == GRID_ZERO);

    assign op_s     = cmd_op_t'(cmd_op);
    assign accept_s = cmd_valid & ready_r;
    assign move     = accept_s & (op_s == MOVE);
    assign dir      = cmd_dir;

    // Per-cell neighbour masks, zero-state flags and the parallel flood step:
    // an unrevealed non-bomb cell opens when any revealed neighbour reads 0.
    for (genvar i = 0; i < N; i++) begin : g_cell
        for (genvar j = 0; j < N; j++) begin : g_nbr
            assign nbr_mask_s[i][j] = cells_adjacent(i, j, GRID_SIZE);
        end
        assign zero_s[i]      = (states[STATE_SIZE*i +: STATE_SIZE] == {STATE_SIZE{1'b0}});
        assign flood_new_s[i] = ~reveal_r[i] & ~bomb_r[i] & (|(nbr_mask_s[i] & reveal_r & zero_s));
    end

    // Next-state and next-grid computation for every game state
    always_comb begin
        state_s    = state_r;
        bomb_s     = bomb_r;
        reveal_s   = reveal_r;
        cursor_s   = cursor_r;
        count_s    = count_r;
        new_game_s = 1'b0;
        case (state_r)
            PLACE: begin
                if (count_r == CNTW'(NUM_BOMBS)) begin
                    state_s = PLAY;
                end else if (place_ok_s) begin
                    bomb_s  = bomb_r | place_bit_s;
                    count_s = count_r + {{(CNTW-1){1'b0}}, 1'b1};
                end else begin
                    count_s = count_r;    // collision or out of range: retry
                end
            end
            PLAY: begin
                // A completed board wins before any command is looked at
                if (&(reveal_r | bomb_r)) begin
                    state_s = WIN;
                end else if (accept_s) begin
                    case (op_s)
                        MOVE: begin
                            if (nextCursorGrid != GRID_ZERO) begin
                                cursor_s = nextCursorGrid;
                            end else begin
                                cursor_s = cursor_r;
                            end
                        end
                        REVEAL: begin
                            if (|(cursor_r & bomb_r)) begin
                                reveal_s = reveal_r | bomb_r;
                                state_s  = LOSE;
                            end else if (|(cursor_r & reveal_r)) begin
                                reveal_s = reveal_r;
                            end else begin
                                reveal_s = reveal_r | cursor_r;
                                if (|(cursor_r & zero_s)) begin
                                    state_s = FLOOD;
                                end else begin
                                    state_s = PLAY;
                                end
                            end
                        end
                        NEW:     new_game_s = 1'b1;
                        default: state_s = state_r;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            FLOOD: begin
                if (flood_new_s == GRID_ZERO) begin
                    state_s = PLAY;
                end else begin
                    reveal_s = reveal_r | flood_new_s;
                end
            end
            WIN, LOSE: begin
                if (accept_s && (op_s == NEW)) begin
                    new_game_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = PLACE;
        endcase

        if (new_game_s) begin
            reveal_s = GRID_ZERO;
            cursor_s = CELL0;
            count_s  = {CNTW{1'b0}};
            if (cmd_grid != GRID_ZERO) begin
                bomb_s  = cmd_grid;
                state_s = PLAY;
            end else begin
                bomb_s  = GRID_ZERO;
                state_s = PLACE;
            end
        end else begin
            count_s = count_s;
        end

        // Ready is registered, so derive it from the state being entered
        ready_s = ((state_s == PLAY) && !(&(reveal_s | bomb_s))) ||
                  (state_s == WIN) || (state_s == LOSE);
    end

    // State and grid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= PLACE;
            bomb_r   <= GRID_ZERO;
            reveal_r <= GRID_ZERO;
            cursor_r <= CELL0;
            count_r  <= {CNTW{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            bomb_r   <= bomb_s;
            reveal_r <= reveal_s;
            cursor_r <= cursor_s;
            count_r  <= count_s;
            ready_r  <= ready_s;
        end
    end

    assign cmd_ready  = ready_r;
    assign bombGrid   = bomb_r;
    assign revealGrid = reveal_r;
    assign cursorGrid = cursor_r;
    assign game_state = state_r;

endmodule

// File: tb/tb_mine_ctrl.sv
// tb_mine_ctrl: self-checking bench for mine_ctrl. A behavioural `board`
// drives states / nextCursorGrid from the DUT grids; a cell-level game model
// (row/col arithmetic, bit arrays) predicts every output each cycle.
module tb_mine_ctrl;
    import mine_pkg::*;

    localparam int          GS   = 3;
    localparam int          N    = GS * GS;
    localparam int          SS   = 4;
    localparam int          NB   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_PLACE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_FLOOD = 2;
    localparam int M_WIN   = 3;
    localparam int M_LOSE  = 4;

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_ready, move;
    logic [1:0]    cmd_op, cmd_dir, dir;
    logic [N-1:0]  cmd_grid, bombGrid, revealGrid, cursorGrid, nextCursorGrid;
    logic [SS*N-1:0] states;
    logic [2:0]    game_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Game model state
    int            m_state;
    logic [N-1:0]  m_bomb, m_rev;
    int            m_cur, m_cnt;
    logic [15:0]   m_lfsr;
    bit            m_init = 1'b0;

    mine_ctrl #(.GRID_SIZE(GS), .STATE_SIZE(SS), .NUM_BOMBS(NB), .SEED(SEED)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_dir        (cmd_dir),
        .cmd_grid       (cmd_grid),
        .bombGrid       (bombGrid),
        .revealGrid     (revealGrid),
        .cursorGrid     (cursorGrid),
        .move           (move),
        .dir            (dir),
        .states         (states),
        .nextCursorGrid (nextCursorGrid),
        .game_state     (game_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit adjacent(int a, int b);
        int ra, ca, rb, cb;
        ra = a / GS; ca = a % GS; rb = b / GS; cb = b % GS;
        return (a != b) && (ra - rb <= 1) && (rb - ra <= 1) && (ca - cb <= 1) && (cb - ca <= 1);
    endfunction

    function automatic int adj_bombs(logic [N-1:0] g, int c);
        int n = 0;
        for (int k = 0; k < N; k++) if (adjacent(c, k) && g[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cell_state(logic [N-1:0] g, int c);
        return (g[c] === 1'b1) ? 9 : adj_bombs(g, c);
    endfunction

    // Cell reached by one step in direction d, or -1 when leaving the grid
    function automatic int step_dir(int c, logic [1:0] d);
        int r, k;
        r = c / GS; k = c % GS;
        case (d)
            2'b00:   k = k - 1;   // right: towards column 0
            2'b01:   r = r + 1;   // up
            2'b10:   k = k + 1;   // left
            default: r = r - 1;   // down
        endcase
        if (r < 0 || r >= GS || k < 0 || k >= GS) return -1;
        return r * GS + k;
    endfunction

    // Behavioural board
    always_comb begin
        states         = '0;
        nextCursorGrid = '0;
        for (int c = 0; c < N; c++) begin
            states[SS*c +: SS] = 4'(cell_state(bombGrid, c));
            if (cursorGrid[c] === 1'b1 && step_dir(c, dir) >= 0) nextCursorGrid[step_dir(c, dir)] = 1'b1;
        end
    end

    function automatic bit model_ready();
        return (m_state == M_PLAY && (m_rev | m_bomb) != 9'h1FF) || m_state == M_WIN || m_state == M_LOSE;
    endfunction

    task automatic model_new(input logic [N-1:0] g);
        m_rev = '0; m_cur = 0; m_cnt = 0;
        if (g != 0) begin m_bomb = g; m_state = M_PLAY; end
        else begin m_bomb = '0; m_state = M_PLACE; end
    endtask

    task automatic model_step(input logic r, input bit acc, input logic [1:0] op,
                              input logic [1:0] d, input logic [N-1:0] g);
        logic [N-1:0] add;
        int idx, nc;
        if (r) begin
            m_bomb = '0; m_rev = '0; m_cur = 0; m_cnt = 0; m_lfsr = SEED; m_state = M_PLACE; m_init = 1'b1;
            return;
        end
        case (m_state)
            M_PLACE: begin
                if (m_cnt == NB) m_state = M_PLAY;
                else begin
                    idx = int'(m_lfsr) % 16;
                    if (idx < N && !m_bomb[idx]) begin m_bomb[idx] = 1'b1; m_cnt++; end
                end
            end
            M_PLAY: begin
                if ((m_rev | m_bomb) == 9'h1FF) m_state = M_WIN;
                else if (acc) begin
                    if (op == 2'd0) begin
                        nc = step_dir(m_cur, d);
                        if (nc >= 0) m_cur = nc;
                    end else if (op == 2'd1) begin
                        if (m_bomb[m_cur]) begin m_rev = m_rev | m_bomb; m_state = M_LOSE; end
                        else if (!m_rev[m_cur]) begin
                            m_rev[m_cur] = 1'b1;
                            if (cell_state(m_bomb, m_cur) == 0) m_state = M_FLOOD;
                        end
                    end else if (op == 2'd2) model_new(g);
                end
            end
            M_FLOOD: begin
                add = '0;
                for (int c = 0; c < N; c++)
                    if (!m_rev[c] && !m_bomb[c])
                        for (int k = 0; k < N; k++)
                            if (adjacent(c, k) && m_rev[k] && cell_state(m_bomb, k) == 0) add[c] = 1'b1;
                if (add == 0) m_state = M_PLAY; else m_rev = m_rev | add;
            end
            default: if (acc && op == 2'd2) model_new(g);
        endcase
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    // One clock: drive inputs, check the combinational strobe, then the
    // registered outputs on the falling edge against the model.
    task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                         input logic [1:0] d, input logic [N-1:0] g);
        bit acc;
        reset = r; cmd_valid = v; cmd_op = op; cmd_dir = d; cmd_grid = g;
        #1;
        acc = !r && m_init && v && model_ready();
        if (!r && m_init) begin
            chk("move", move, acc && op == 2'd0);
            chk("dir", dir, d);
        end
        @(posedge clk);
        model_step(r, acc, op, d, g);
        @(negedge clk);
        chk("state", game_state, m_state);
        chk("ready", cmd_ready, model_ready());
        chk("bomb", bombGrid, m_bomb);
        chk("reveal", revealGrid, m_rev);
        chk("cursor", cursorGrid, 9'h001 << m_cur);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           got;
        logic         r, v;
        logic [1:0]   op, d;
        logic [N-1:0] g;
        int           p, nb;

        // Reset
        cycle(1'b1, 1'b0, 2'd0, 2'd0, '0);
        cycle(1'b1, 1'b0, 2'd0, 2'd0, '0);
        chk("rst_bomb", bombGrid, 9'h000);
        chk("rst_reveal", revealGrid, 9'h000);
        chk("rst_cursor", cursorGrid, 9'h001);
        chk("rst_state", game_state, 3'd0);
        chk("rst_ready", cmd_ready, 1'b0);

        // Random placement
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 2'd0, '0);
            if (game_state == 3'd1) got = 1'b1;
        end
        chk("place_done", got, 1'b1);
        chk("place_pop", $countones(bombGrid), 2);

        // Edge block and move up
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 9'h100);
        cycle(1'b0, 1'b1, 2'd0, 2'b00, '0);
        chk("edge_right", cursorGrid, 9'h001);
        cycle(1'b0, 1'b1, 2'd0, 2'b01, '0);
        chk("move_up", cursorGrid, 9'h008);

        // Flood to win
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 9'h100);
        cycle(1'b0, 1'b1, 2'd1, 2'd0, '0);
        chk("flood_enter", game_state, 3'd2);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 2'd0, '0);
            if (revealGrid == 9'h0FF) got = 1'b1;
        end
        chk("flood_reveal", revealGrid, 9'h0FF);
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 2'd0, '0);
            if (game_state == 3'd1) got = 1'b1;
        end
        chk("flood_play", game_state, 3'd1);
        cycle(1'b0, 1'b0, 2'd0, 2'd0, '0);
        chk("win", game_state, 3'd3);

        // Lose, then an ignored move
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 9'h001);
        cycle(1'b0, 1'b1, 2'd1, 2'd0, '0);
        chk("lose_reveal", revealGrid, 9'h001);
        chk("lose_state", game_state, 3'd4);
        cycle(1'b0, 1'b1, 2'd0, 2'b01, '0);
        chk("lose_move", cursorGrid, 9'h001);

        // Reset mid-flood
        cycle(1'b0, 1'b1, 2'd2, 2'd0, 9'h100);
        cycle(1'b0, 1'b1, 2'd1, 2'd0, '0);
        cycle(1'b0, 1'b0, 2'd0, 2'd0, '0);
        chk("midflood_state", game_state, 3'd2);
        cycle(1'b1, 1'b0, 2'd0, 2'd0, '0);
        chk("midflood_rst_state", game_state, 3'd0);
        chk("midflood_rst_reveal", revealGrid, 9'h000);
        chk("midflood_rst_cursor", cursorGrid, 9'h001);

        // Randomized play against the model
        for (int i = 0; i < 2500; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 9) < 8);
            p  = $urandom_range(0, 99);
            op = (p < 45) ? 2'd0 : (p < 75) ? 2'd1 : (p < 92) ? 2'd2 : 2'd3;
            d  = 2'($urandom_range(0, 3));
            g  = '0;
            if ($urandom_range(0, 9) < 7) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) g[$urandom_range(0, N-1)] = 1'b1;
            end
            cycle(r, v, op, d, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
